univ_shift_reg: RTL and testbench

Parameterizable universal shift register with hold, shift-right, shift-left and parallel-load modes, plus a shift counter that flags each completed frame of WIDTH shifts. It sits directly downstream of the single-bit flip-flop stage and consumes its registered Q output as serial input. It provides the multi-bit register, serial-to-parallel and parallel-to-serial capability that the datapath exercises need.

---
 rtl/univ_shift_reg.sv | 68 ++++++
 tb/tb_univ_shift_reg.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load,
// with a shift counter that pulses frame_done every WIDTH shifts.
module univ_shift_reg #(
    parameter  int             WIDTH     = 4,
    parameter  logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             CW        = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    shift_cnt,
    output logic             frame_done
);

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_RIGHT = 2'b01;
    localparam logic [1:0] M_LEFT  = 2'b10;
    localparam logic [1:0] M_LOAD  = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic is_shift;
    logic cnt_last;

    assign is_shift = (mode == M_RIGHT) || (mode == M_LEFT);
    assign cnt_last = (shift_cnt == CNT_LAST);

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= RESET_VAL;
        end else begin
            // Unknown mode values fall through to hold.
            case (mode)
                M_RIGHT: q <= {sin_r, q[WIDTH-1:1]};
                M_LEFT:  q <= {q[WIDTH-2:0], sin_l};
                M_LOAD:  q <= pin;
                M_HOLD:  q <= q;
                default: q <= q;
            endcase
        end
    end

    // Left and right shifts share one frame count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else if (mode == M_LOAD) begin
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else if (is_shift) begin
            shift_cnt  <= cnt_last ? '0 : shift_cnt + 1'b1;
            frame_done <= cnt_last;
        end else begin
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=4).
module tb_univ_shift_reg;

    logic       clock;
    logic       reset_n;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [3:0] pin;
    logic [3:0] q;
    logic       sout_r;
    logic       sout_l;
    logic [1:0] shift_cnt;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] q;
        logic [1:0] cnt;
        logic       fd;
    } exp_t;

    exp_t       sbq[$];
    exp_t       e;
    logic [3:0] mq;
    logic [1:0] mcnt;
    logic       mfd;

    univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .pin        (pin),
        .q          (q),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Drive one cycle, advance the model, push the expectation.
    task automatic drive(input logic [1:0] m, input logic r,
                         input logic l, input logic [3:0] p);
        logic [3:0] nq;
        @(negedge clock);
        mode  = m;
        sin_r = r;
        sin_l = l;
        pin   = p;
        nq    = mq;
        mfd   = 1'b0;
        if (m == 2'b01) begin
            for (int i = 0; i < 3; i++) nq[i] = mq[i+1];
            nq[3] = r;
        end else if (m == 2'b10) begin
            for (int i = 3; i > 0; i--) nq[i] = mq[i-1];
            nq[0] = l;
        end else if (m == 2'b11) begin
            nq = p;
        end
        if (m == 2'b01 || m == 2'b10) begin
            if (mcnt == 2'd3) begin
                mcnt = 2'd0;
                mfd  = 1'b1;
            end else begin
                mcnt = mcnt + 2'd1;
            end
        end else if (m == 2'b11) begin
            mcnt = 2'd0;
        end
        mq = nq;
        sbq.push_back('{q: mq, cnt: mcnt, fd: mfd});
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        mq   = 4'b0000;
        mcnt = 2'd0;
        mfd  = 1'b0;
        sbq.delete();
    endtask

    task automatic test_reset();
        drive(2'b11, 0, 0, 4'b1111);
        void'(sbq.pop_front());
        drive(2'b01, 1, 0, 4'b0000);
        void'(sbq.pop_front());
        drive(2'b01, 1, 0, 4'b0000);
        e = sbq.pop_front();
        checks++;
        if (q !== 4'b1111 || shift_cnt !== 2'd2 || e.q !== q) begin
            failures++;
            $display("FAIL pre_reset q=%b cnt=%0d want q=1111 cnt=2", q, shift_cnt);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (q !== 4'b0000 || shift_cnt !== 2'd0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset q=%b cnt=%0d fd=%b want 0000/0/0", q, shift_cnt, frame_done);
        end
        @(negedge clock);
        mode = 2'b11;
        pin  = 4'b1001;
        #2;
        reset_n = 1'b1;
        #1;
        checks++;
        if (q !== 4'b0000 || shift_cnt !== 2'd0) begin
            failures++;
            $display("FAIL reset_release q=%b cnt=%0d want 0000/0", q, shift_cnt);
        end
        mode = 2'b00;
    endtask

    task automatic test_load_right();
        drive(2'b11, 0, 0, 4'b1010);
        void'(sbq.pop_front());
        drive(2'b01, 1, 0, 4'b0000);
        e = sbq.pop_front();
        checks++;
        if (q !== e.q || q !== 4'b1101 || sout_r !== 1'b1 || shift_cnt !== e.cnt) begin
            failures++;
            $display("FAIL load_right q=%b sout_r=%b want q=1101 sout_r=1", q, sout_r);
        end
    endtask

    task automatic test_load_left();
        drive(2'b11, 0, 0, 4'b1010);
        void'(sbq.pop_front());
        drive(2'b10, 0, 0, 4'b0000);
        e = sbq.pop_front();
        checks++;
        if (q !== e.q || q !== 4'b0100 || sout_l !== 1'b0 || shift_cnt !== e.cnt) begin
            failures++;
            $display("FAIL load_left q=%b sout_l=%b want q=0100 sout_l=0", q, sout_l);
        end
    endtask

    task automatic test_serial_frame();
        logic [3:0] bits;
        logic [1:0] cnt_seq [4];
        bits = 4'b1101;
        cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
        drive(2'b11, 0, 0, 4'b0000);
        void'(sbq.pop_front());
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, bits[i], 0, 4'b0000);
            e = sbq.pop_front();
            checks++;
            if (q !== e.q || shift_cnt !== cnt_seq[i] ||
                frame_done !== (i == 3) || sout_r !== e.q[0]) begin
                failures++;
                $display("FAIL serial_frame[%0d] q=%b cnt=%0d fd=%b want q=%b cnt=%0d fd=%b",
                         i, q, shift_cnt, frame_done, e.q, cnt_seq[i], i == 3);
            end
        end
        checks++;
        if (q !== 4'b1101) begin
            failures++;
            $display("FAIL serial_final q=%b want 1101", q);
        end
    endtask

    task automatic test_hold_mixed();
        logic [1:0] ms [7];
        ms = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
        drive(2'b11, 0, 0, 4'b0011);
        void'(sbq.pop_front());
        for (int i = 0; i < 7; i++) begin
            drive(ms[i], 1, 1, 4'b0000);
            e = sbq.pop_front();
            checks++;
            if (q !== e.q || shift_cnt !== e.cnt || frame_done !== e.fd ||
                sout_r !== e.q[0] || sout_l !== e.q[3]) begin
                failures++;
                $display("FAIL hold_mixed[%0d] q=%b cnt=%0d fd=%b want q=%b cnt=%0d fd=%b",
                         i, q, shift_cnt, frame_done, e.q, e.cnt, e.fd);
            end
        end
        checks++;
        if (frame_done !== 1'b1 || shift_cnt !== 2'd0) begin
            failures++;
            $display("FAIL hold_mixed_pulse fd=%b cnt=%0d want 1/0", frame_done, shift_cnt);
        end
    endtask

    task automatic test_load_interrupt();
        drive(2'b11, 0, 0, 4'b0000);
        void'(sbq.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, 1, 1, 4'b0000);
            void'(sbq.pop_front());
        end
        drive(2'b11, 0, 0, 4'b0110);
        e = sbq.pop_front();
        checks++;
        if (q !== 4'b0110 || shift_cnt !== 2'd0 || frame_done !== 1'b0 || e.q !== q) begin
            failures++;
            $display("FAIL load_interrupt q=%b cnt=%0d fd=%b want 0110/0/0", q, shift_cnt, frame_done);
        end
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 0, 0, 4'b0000);
            e = sbq.pop_front();
            checks++;
            if (q !== e.q || shift_cnt !== e.cnt || frame_done !== (i == 3)) begin
                failures++;
                $display("FAIL post_load[%0d] q=%b cnt=%0d fd=%b want q=%b cnt=%0d fd=%b",
                         i, q, shift_cnt, frame_done, e.q, e.cnt, i == 3);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        drive(2'b11, 0, 0, 4'b1001);
        void'(sbq.pop_front());
        for (int i = 0; i < 12; i++) begin
            drive((i % 3 == 0) ? 2'b10 : 2'b01, 1'($urandom), 1'($urandom), 4'b0000);
            e = sbq.pop_front();
            pulses += int'(frame_done);
            checks++;
            if (q !== e.q || shift_cnt !== e.cnt || frame_done !== e.fd) begin
                failures++;
                $display("FAIL b2b[%0d] q=%b cnt=%0d fd=%b want q=%b cnt=%0d fd=%b",
                         i, q, shift_cnt, frame_done, e.q, e.cnt, e.fd);
            end
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL b2b_pulses got=%0d want=3", pulses);
        end
        drive(2'b11, 0, 0, 4'b0101);
        e = sbq.pop_front();
        checks++;
        if (q !== 4'b0101 || frame_done !== 1'b0 || shift_cnt !== 2'd0) begin
            failures++;
            $display("FAIL load_after_wrap q=%b cnt=%0d fd=%b want 0101/0/0", q, shift_cnt, frame_done);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        mode    = 2'b00;
        sin_r   = 1'b0;
        sin_l   = 1'b0;
        pin     = 4'b0000;
        model_reset();
        #1;
        checks++;
        if (q !== 4'b0000 || shift_cnt !== 2'd0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL init_reset q=%b cnt=%0d fd=%b want 0000/0/0", q, shift_cnt, frame_done);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        test_reset();
        test_load_right();
        test_load_left();
        test_serial_frame();
        test_hold_mixed();
        test_load_interrupt();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
